// File: rtl/pwm_pkg.sv
// Shared types for the PWM generator / capture pair.
package pwm_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_e;

endpackage

// File: rtl/sync_edge.sv
// Synchroniser for an asynchronous pin plus a delay flop for edge detection.
// Rise and fall come from the same flop pair, so both edges see identical latency.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures PWM period and high time in clk cycles; one strobe per completed cycle.
// A missing rising edge for TIMEOUT cycles raises a sticky timeout and re-arms.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TIMEOUT     = 16'hFFFF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             meas_valid,
  output logic             timeout,
  output logic             level_o
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  logic             rise;
  logic             fall;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] hi_len_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] high_q;
  logic             meas_valid_q;
  logic             timeout_q;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .rst    (rst),
    .d_i    (pwm_in),
    .level_o(level_o),
    .rise_o (rise),
    .fall_o (fall)
  );

  assign cnt_d = cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hi_len_q     <= '0;
      period_q     <= '0;
      high_q       <= '0;
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      meas_valid_q <= 1'b0;
      if (!en) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        hi_len_q  <= '0;
        timeout_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            cnt_q    <= '0;
            hi_len_q <= '0;
            state_q  <= ARM;
          end
          ARM: begin
            if (rise) begin
              cnt_q   <= CNT_W'(1);
              state_q <= MEAS;
            end
          end
          MEAS: begin
            // A rise always closes the period, even on the timeout cycle.
            if (rise) begin
              period_q     <= cnt_q;
              high_q       <= hi_len_q;
              meas_valid_q <= 1'b1;
              timeout_q    <= 1'b0;
              cnt_q        <= CNT_W'(1);
            end else if (cnt_q == TMO) begin
              timeout_q <= 1'b1;
              cnt_q     <= '0;
              state_q   <= ARM;
            end else begin
              cnt_q <= cnt_d;
              if (fall) hi_len_q <= cnt_q;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign period_o   = period_q;
  assign high_o     = high_q;
  assign meas_valid = meas_valid_q;
  assign timeout    = timeout_q;

endmodule
